// File: rtl/viterbi_pkg.sv
// Shared Viterbi constants: default trellis sizing and the all-ones
// path-metric helper used for "unreachable" states.
package viterbi_pkg;

    localparam int PM_W_DEF        = 8;
    localparam int NUM_STATES_DEF  = 4;
    localparam int START_STATE_DEF = 0;

    // Low w bits set; callers slice the width they need.
    function automatic logic [63:0] pm_ones(input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pm_min_tree.sv
// Combinational minimum search over N packed W-bit values; returns value and
// index, ties resolved toward the lowest index.
module pm_min_tree #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N*W-1:0]       vals_i,
    output logic [W-1:0]         min_val_o,
    output logic [$clog2(N)-1:0] min_idx_o
);

    localparam int IW = $clog2(N);

    // Heap-ordered nodes: root at 0, leaves N-1..2N-2 in ascending state order,
    // so a left child always covers lower indices than its sibling.
    logic [W-1:0]  nv [2*N-1];
    logic [IW-1:0] ni [2*N-1];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            nv[N-1+k] = vals_i[k*W +: W];
            ni[N-1+k] = IW'(k);
        end
        for (int i = N-2; i >= 0; i--) begin
            if (nv[2*i+1] <= nv[2*i+2]) begin
                nv[i] = nv[2*i+1];
                ni[i] = ni[2*i+1];
            end else begin
                nv[i] = nv[2*i+2];
                ni[i] = ni[2*i+2];
            end
        end
    end

    assign min_val_o = nv[0];
    assign min_idx_o = ni[0];

endmodule

// File: rtl/pmu_norm.sv
// Path-metric register with threshold normalisation and best-state tracking.
// Define PMU_NORM_CNT_EN to build the saturating normalisation-event counter.
module pmu_norm
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES  = NUM_STATES_DEF,
    parameter int PM_W        = PM_W_DEF,
    parameter int START_STATE = START_STATE_DEF,
    parameter int NORM_THRESH = 2**(PM_W-1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_i,
    input  logic                          valid_i,
    input  logic [NUM_STATES*PM_W-1:0]    pm_new_i,
    output logic [NUM_STATES*PM_W-1:0]    pm_current_o,
    output logic [$clog2(NUM_STATES)-1:0] best_state_o,
    output logic [PM_W-1:0]               best_pm_o,
    output logic                          norm_o,
    output logic                          valid_o,
    output logic [15:0]                   norm_cnt_o
);

    localparam int                IW        = $clog2(NUM_STATES);
    localparam logic [63:0]       ONES64    = pm_ones(PM_W);
    localparam logic [PM_W-1:0]   PM_ONES   = ONES64[PM_W-1:0];
    localparam logic [PM_W-1:0]   THRESH    = PM_W'(NORM_THRESH);
    localparam logic [IW-1:0]     START_IDX = IW'(START_STATE);

    typedef logic [NUM_STATES-1:0][PM_W-1:0] pm_vec_t;

    pm_vec_t         pm_new, pm_sub, pm_rst, pm_d, pm_q;
    logic [PM_W-1:0] m_new;
    logic [IW-1:0]   new_min_idx_unused;
    logic [PM_W-1:0] best_pm_d, best_pm_q;
    logic [IW-1:0]   best_state_d, best_state_q;
    logic            norm_d, norm_q, valid_d, valid_q;

    assign pm_new = pm_new_i;

    pm_min_tree #(.N(NUM_STATES), .W(PM_W)) u_min_new (
        .vals_i    (pm_new_i),
        .min_val_o (m_new),
        .min_idx_o (new_min_idx_unused)
    );

    // m is the minimum, so every difference is non-negative.
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
        assign pm_sub[s] = pm_new[s] - m_new;
        assign pm_rst[s] = (s == START_STATE) ? '0 : PM_ONES;
    end

    always_comb begin
        pm_d    = pm_q;
        norm_d  = 1'b0;
        valid_d = 1'b0;
        if (init_i) begin
            pm_d = pm_rst;
        end else if (valid_i) begin
            valid_d = 1'b1;
            norm_d  = (m_new >= THRESH);
            pm_d    = norm_d ? pm_sub : pm_new;
        end
    end

    // Best state is searched on the value about to be stored, so it is
    // registered alongside the metrics it describes.
    pm_min_tree #(.N(NUM_STATES), .W(PM_W)) u_min_best (
        .vals_i    (pm_d),
        .min_val_o (best_pm_d),
        .min_idx_o (best_state_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q         <= pm_rst;
            best_state_q <= START_IDX;
            best_pm_q    <= '0;
            norm_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            pm_q         <= pm_d;
            best_state_q <= best_state_d;
            best_pm_q    <= best_pm_d;
            norm_q       <= norm_d;
            valid_q      <= valid_d;
        end
    end

`ifdef PMU_NORM_CNT_EN
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (norm_d && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign norm_cnt_o = cnt_q;
`else
    assign norm_cnt_o = '0;
`endif

    assign pm_current_o = pm_q;
    assign best_state_o = best_state_q;
    assign best_pm_o    = best_pm_q;
    assign norm_o       = norm_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_pmu_norm.sv
// Directed bench for pmu_norm at default sizing (4 states, 8-bit metrics,
// threshold 128) with a behavioural reference model and literal spot checks.
module tb_pmu_norm;

`ifdef PMU_NORM_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk, rst_n, init_i, valid_i;
    logic [31:0] pm_new_i, pm_current_o;
    logic [1:0]  best_state_o;
    logic [7:0]  best_pm_o;
    logic        norm_o, valid_o;
    logic [15:0] norm_cnt_o;

    pmu_norm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_i       (init_i),
        .valid_i      (valid_i),
        .pm_new_i     (pm_new_i),
        .pm_current_o (pm_current_o),
        .best_state_o (best_state_o),
        .best_pm_o    (best_pm_o),
        .norm_o       (norm_o),
        .valid_o      (valid_o),
        .norm_cnt_o   (norm_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pm_at(input int s);
        return int'(pm_current_o[s*8 +: 8]);
    endfunction

    // Reference model: plain integer arithmetic on the spec's rules.
    int e_pm[4];
    int e_best, e_bpm, e_cnt;
    bit e_norm, e_vld;
    int mm, v[4], pmin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || init_i) begin
            e_pm = '{0, 255, 255, 255};
            e_best = 0; e_bpm = 0; e_norm = 0; e_vld = 0;
            if (!rst_n) e_cnt = 0;
        end else if (valid_i) begin
            mm = 256;
            for (int s = 0; s < 4; s++) begin
                v[s] = int'(pm_new_i[s*8 +: 8]);
                if (v[s] < mm) mm = v[s];
            end
            e_norm = (mm >= 128);
            for (int s = 0; s < 4; s++) e_pm[s] = e_norm ? v[s] - mm : v[s];
            if (e_norm && CNT_EN && e_cnt < 65535) e_cnt++;
            pmin = 256;
            for (int s = 0; s < 4; s++) begin
                if (e_pm[s] < pmin) begin pmin = e_pm[s]; e_best = s; end
            end
            e_bpm = pmin;
            e_vld = 1;
        end else begin
            e_norm = 0; e_vld = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int s = 0; s < 4; s++) chk($sformatf("model pm[%0d]", s), pm_at(s), e_pm[s]);
            chk("model best_state", int'(best_state_o), e_best);
            chk("model best_pm", int'(best_pm_o), e_bpm);
            chk("model norm", int'(norm_o), int'(e_norm));
            chk("model valid", int'(valid_o), int'(e_vld));
            chk("model norm_cnt", int'(norm_cnt_o), e_cnt);
        end
    end

    task automatic apply(input int a, input int b, input int c, input int d,
                         input bit v_in, input bit ini);
        pm_new_i = {8'(d), 8'(c), 8'(b), 8'(a)};
        valid_i  = v_in;
        init_i   = ini;
        @(negedge clk);
        valid_i  = 1'b0;
        init_i   = 1'b0;
    endtask

    task automatic lit_pm(input string nm, input int a, input int b, input int c, input int d);
        chk({nm, " pm0"}, pm_at(0), a);
        chk({nm, " pm1"}, pm_at(1), b);
        chk({nm, " pm2"}, pm_at(2), c);
        chk({nm, " pm3"}, pm_at(3), d);
    endtask

    task automatic lit_reset(input string nm);
        lit_pm(nm, 0, 255, 255, 255);
        chk({nm, " best_state"}, int'(best_state_o), 0);
        chk({nm, " best_pm"}, int'(best_pm_o), 0);
        chk({nm, " valid"}, int'(valid_o), 0);
        chk({nm, " norm"}, int'(norm_o), 0);
        chk({nm, " norm_cnt"}, int'(norm_cnt_o), 0);
    endtask

    initial begin
        rst_n = 1'b0; init_i = 1'b0; valid_i = 1'b0; pm_new_i = '0;
        repeat (2) @(negedge clk);
        lit_reset("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        apply(10, 20, 30, 40, 1, 0);
        lit_pm("update", 10, 20, 30, 40);
        chk("update best_state", int'(best_state_o), 0);
        chk("update best_pm", int'(best_pm_o), 10);
        chk("update norm", int'(norm_o), 0);
        chk("update valid", int'(valid_o), 1);

        apply(130, 140, 200, 255, 1, 0);
        lit_pm("normalise", 0, 10, 70, 125);
        chk("normalise norm", int'(norm_o), 1);
        chk("normalise best_pm", int'(best_pm_o), 0);
        chk("normalise norm_cnt", int'(norm_cnt_o), CNT_EN ? 1 : 0);

        apply(127, 200, 200, 200, 1, 0);
        lit_pm("below thresh", 127, 200, 200, 200);
        chk("below thresh norm", int'(norm_o), 0);

        apply(200, 129, 255, 128, 1, 0);
        lit_pm("at thresh", 72, 1, 127, 0);
        chk("at thresh norm", int'(norm_o), 1);
        chk("at thresh best_state", int'(best_state_o), 3);
        chk("at thresh norm_cnt", int'(norm_cnt_o), CNT_EN ? 2 : 0);

        apply(127, 128, 255, 200, 1, 0);
        lit_pm("thresh-1", 127, 128, 255, 200);
        chk("thresh-1 norm", int'(norm_o), 0);

        for (int i = 0; i < 5; i++) begin
            apply(int'($urandom_range(0, 255)), int'($urandom_range(128, 255)),
                  i * 50, 255 - i, 0, 0);
            lit_pm("hold", 127, 128, 255, 200);
            chk("hold best_pm", int'(best_pm_o), 127);
            chk("hold norm", int'(norm_o), 0);
            chk("hold valid", int'(valid_o), 0);
        end

        apply(50, 30, 30, 90, 1, 0);
        chk("tie best_state", int'(best_state_o), 1);
        chk("tie best_pm", int'(best_pm_o), 30);

        apply(5, 5, 5, 5, 1, 1);
        lit_pm("init", 0, 255, 255, 255);
        chk("init valid", int'(valid_o), 0);
        chk("init best_state", int'(best_state_o), 0);
        chk("init norm_cnt", int'(norm_cnt_o), CNT_EN ? 2 : 0);

        for (int i = 0; i < 24; i++) begin
            apply(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(100, 255)), int'($urandom_range(120, 255)),
                  1'($urandom_range(0, 3) != 0), 0);
        end

        // Asynchronous reset arriving while an update is pending.
        pm_new_i = {8'd200, 8'd210, 8'd220, 8'd230};
        valid_i  = 1'b1;
        #2 rst_n = 1'b0;
        #1 lit_reset("async reset");
        @(negedge clk);
        lit_reset("reset held");
        valid_i = 1'b0;
        rst_n   = 1'b1;
        apply(140, 150, 160, 170, 1, 0);
        lit_pm("post reset", 0, 10, 20, 30);
        chk("post reset norm_cnt", int'(norm_cnt_o), CNT_EN ? 1 : 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pmu_norm.md
PMU_NORM -- requirements
Module: pmu_norm

Interface
REQ-001 Parameter NUM_STATES, default 4, number of trellis states; SHALL be a power of 2, 2..64.
REQ-002 Parameter PM_W, default 8, path-metric width in bits.
REQ-003 Parameter START_STATE, default 0, state whose metric is 0 after reset/init.
REQ-004 Parameter NORM_THRESH, default 2**(PM_W-1), minimum-metric level that triggers normalisation.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 init_i  in  1  synchronous restart to reset metric values (new frame).
REQ-008 valid_i  in  1  pm_new_i is valid this cycle.
REQ-009 pm_new_i  in  NUM_STATES*PM_W  new metrics from ACS, state s in bits [s*PM_W +: PM_W].
REQ-010 pm_current_o  out  NUM_STATES*PM_W  registered metrics, same packing.
REQ-011 best_state_o  out  $clog2(NUM_STATES)  index of minimum registered metric.
REQ-012 best_pm_o  out  PM_W  value of that minimum.
REQ-013 norm_o  out  1  one-cycle pulse: the current update was normalised.
REQ-014 valid_o  out  1  registered copy of valid_i (cleared by init_i).
REQ-015 norm_cnt_o  out  16  count of normalisation events (see Configuration).

Function
REQ-016 Latency SHALL be 1 cycle: pm_current_o, best_state_o, best_pm_o, norm_o and valid_o all reflect the valid_i cycle on the following edge.
REQ-017 The block SHALL compute m = min over all states of pm_new_i, unsigned.
REQ-018 On valid_i=1 with m >= NORM_THRESH: SHALL store pm_new_i[s] - m for every s and set norm_o=1.
REQ-019 On valid_i=1 with m < NORM_THRESH: SHALL store pm_new_i unchanged and set norm_o=0.
REQ-020 Boundary: m == NORM_THRESH normalises; m == NORM_THRESH-1 does not.
REQ-021 On valid_i=0: pm_current_o, best_state_o and best_pm_o SHALL hold; norm_o=0; valid_o=0.
REQ-022 best_state_o/best_pm_o SHALL be derived from the stored (post-normalisation) values; ties resolve to the lowest index.
REQ-023 Subtraction SHALL never underflow, because m is the minimum; no saturation logic is required.
REQ-024 init_i=1 SHALL load reset values on the next edge and take priority over a simultaneous valid_i.
REQ-025 init_i SHALL NOT clear norm_cnt_o.

Reset
REQ-026 While rst_n=0 the block SHALL drive pm_current_o[START_STATE]=0, all other states all-ones, best_state_o=START_STATE, best_pm_o=0, norm_o=0, valid_o=0, norm_cnt_o=0.
REQ-027 rst_n asserted mid-stream SHALL discard any in-flight update immediately.

Configuration
REQ-028 Macro PMU_NORM_CNT_EN defined: norm_cnt_o SHALL increment on each normalised update and saturate at 16'hFFFF.
REQ-029 Macro PMU_NORM_CNT_EN undefined: the counter is absent and norm_cnt_o SHALL be constant 0.

Structure
REQ-030 Shared package viterbi_pkg SHALL hold the default PM_W, NUM_STATES and START_STATE constants and the function giving the all-ones metric value.
REQ-031 The minimum search SHALL be one combinational sub-module, pm_min_tree (value plus index, lowest-index tie-break), instantiated twice: once for normalisation and once for best-state selection.

Verification (defaults: 4 states, PM_W=8, NORM_THRESH=128)
REQ-032 Reset: rst_n=0 -> pm_current {0,255,255,255}, best_state 0, best_pm 0, valid_o 0, norm_cnt 0.
REQ-033 Update: valid_i with {10,20,30,40} -> next edge pm {10,20,30,40}, best_state 0, best_pm 10, norm_o 0, valid_o 1.
REQ-034 Normalise: {130,140,200,255} -> pm {0,10,70,125}, norm_o 1, best_pm 0, norm_cnt 1 (with macro); {127,200,200,200} -> stored unchanged, norm_o 0.
REQ-035 Hold: valid_i=0 for 5 cycles while pm_new_i toggles -> outputs unchanged, norm_o 0, valid_o 0.
REQ-036 Tie: {50,30,30,90} -> best_state 1, best_pm 30.
REQ-037 Init: init_i=1 together with valid_i {5,5,5,5} -> pm {0,255,255,255}, valid_o 0, norm_cnt unchanged.
